// File: rtl/epc_pkg.sv
// Shared definitions for the EPC register-bus controller: state encoding,
// error read data and the reserved control word address.
package epc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACCESS,
        ST_RESP,
        ST_HOLD
    } epc_state_t;

    localparam logic [31:0] EPC_ERR_DATA  = 32'hdead_beef;
    localparam logic [31:0] EPC_CTRL_ADDR = 32'h0000_0000;

    // Any byte lane of the control word selects it.
    function automatic logic is_ctrl_word(input logic [31:0] addr);
        return addr[31:2] == EPC_CTRL_ADDR[31:2];
    endfunction

endpackage

// File: rtl/epc_decode.sv
// Combinational EPC address decode: one-hot slave select from the index
// field plus a flag for any address bit outside the mapped window.
module epc_decode
    import epc_pkg::*;
#(
    parameter int SEL_LSB = 8,
    parameter int SEL_W   = 5,
    parameter int ADDR_W  = 16
) (
    input  logic [31:0]             i_addr,
    output logic [(2**SEL_W)-1:0]   o_sel,
    output logic                    o_unmapped
);

    localparam int NSLV  = 2**SEL_W;
    // Everything from the lower of ADDR_W and the index-field top upwards is unmapped.
    localparam int MAP_W = (ADDR_W < SEL_LSB + SEL_W) ? ADDR_W : (SEL_LSB + SEL_W);
    localparam logic [32:0] MAP_BITS   = (33'd1 << MAP_W) - 33'd1;
    localparam logic [31:0] UNMAP_MASK = ~MAP_BITS[31:0];

    logic [SEL_W-1:0] w_idx;

    assign w_idx      = i_addr[SEL_LSB +: SEL_W];
    assign o_sel      = {{(NSLV-1){1'b0}}, 1'b1} << w_idx;
    assign o_unmapped = |(i_addr & UNMAP_MASK);

endmodule

// File: rtl/epc_reg_ctl.sv
// EPC register-bus controller: decodes single-beat EPC accesses onto NSLV
// register slaves with a request/ack handshake, timeout and error tracking.
module epc_reg_ctl
    import epc_pkg::*;
#(
    parameter int          SEL_LSB  = 8,
    parameter int          SEL_W    = 5,
    parameter int          ADDR_W   = 16,
    parameter int          TMO      = 16,
    parameter logic [31:0] ERR_DATA = EPC_ERR_DATA
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        epc_cs_n,
    input  logic                        epc_ads,
    input  logic                        epc_rnw,
    input  logic [31:0]                 epc_addr,
    input  logic [3:0]                  epc_be,
    input  logic [31:0]                 epc_wdata,
    output logic [31:0]                 epc_rdata,
    output logic                        epc_rdy,
    output logic [(2**SEL_W)-1:0]       reg_sel,
    output logic [SEL_LSB-3:0]          reg_addr,
    output logic [3:0]                  reg_be,
    output logic [31:0]                 reg_wdata,
    output logic                        reg_wr,
    output logic                        reg_rd,
    input  logic [32*(2**SEL_W)-1:0]    reg_rdata,
    input  logic [(2**SEL_W)-1:0]       reg_ack,
    output logic                        err_flag,
    output logic [15:0]                 err_cnt
);

    localparam int NSLV = 2**SEL_W;
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    epc_state_t         r_state;
    logic [31:0]        r_addr;
    logic               r_rnw;
    logic [15:0]        r_cnt;
    logic               r_rdy;
    logic [31:0]        r_rdata;
    logic [NSLV-1:0]    r_sel;
    logic               r_wr;
    logic               r_rd;
    logic [SEL_LSB-3:0] r_reg_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic               r_err_flag;
    logic [15:0]        r_err_cnt;

    logic [NSLV-1:0]    w_sel;
    logic               w_unmapped;
    logic [SEL_W-1:0]   w_idx;
    logic [SEL_W+4:0]   w_base;
    logic [31:0]        w_slv_rdata;
    logic               w_active;
    logic               w_ack;
    logic               w_timeout;
    logic               w_ctrl_wr;
    logic               w_err_evt;
    logic               w_clr_evt;
    logic [15:0]        w_err_cnt_nxt;

    epc_decode #(
        .SEL_LSB (SEL_LSB),
        .SEL_W   (SEL_W),
        .ADDR_W  (ADDR_W)
    ) u_decode (
        .i_addr     (r_addr),
        .o_sel      (w_sel),
        .o_unmapped (w_unmapped)
    );

    assign w_idx       = r_addr[SEL_LSB +: SEL_W];
    assign w_base      = {w_idx, 5'd0};
    assign w_slv_rdata = reg_rdata[w_base +: 32];
    assign w_active    = ~epc_cs_n;
    assign w_ack       = |(reg_ack & r_sel);
    assign w_timeout   = (r_cnt == TMO_LAST);
    assign w_ctrl_wr   = ~r_rnw & is_ctrl_word(r_addr);

    // Error/clear events are only honoured while the EPC still holds chip select.
    assign w_err_evt = w_active &
                       (((r_state == ST_DECODE) & w_unmapped) |
                        ((r_state == ST_ACCESS) & ~w_ack & w_timeout));
    assign w_clr_evt = w_active & (r_state == ST_DECODE) & ~w_unmapped & w_ctrl_wr;

    assign w_err_cnt_nxt = w_clr_evt ? 16'd0 :
                           (w_err_evt && r_err_cnt != 16'hffff) ? r_err_cnt + 16'd1 :
                           r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_rnw      <= 1'b0;
            r_cnt      <= '0;
            r_rdy      <= 1'b0;
            r_rdata    <= '0;
            r_sel      <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_reg_addr <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_rdy     <= 1'b0;
            r_err_cnt <= w_err_cnt_nxt;
            if (w_clr_evt) begin
                r_err_flag <= 1'b0;
            end else if (w_err_evt) begin
                r_err_flag <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (!epc_cs_n && epc_ads) begin
                        r_addr     <= epc_addr;
                        r_rnw      <= epc_rnw;
                        r_be       <= epc_be;
                        r_wdata    <= epc_wdata;
                        r_reg_addr <= epc_addr[SEL_LSB-1:2];
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (epc_cs_n) begin
                        r_state <= ST_IDLE;
                    end else if (w_unmapped) begin
                        r_rdy   <= 1'b1;
                        r_rdata <= r_rnw ? ERR_DATA : 32'd0;
                        r_state <= ST_RESP;
                    end else if (w_ctrl_wr) begin
                        r_rdy   <= 1'b1;
                        r_rdata <= 32'd0;
                        r_state <= ST_RESP;
                    end else begin
                        r_sel   <= w_sel;
                        r_wr    <= ~r_rnw;
                        r_rd    <= r_rnw;
                        r_cnt   <= '0;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final timeout cycle still completes cleanly.
                    if (epc_cs_n) begin
                        r_sel   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_ack) begin
                        r_sel   <= '0;
                        r_rdy   <= 1'b1;
                        r_rdata <= r_rnw ? w_slv_rdata : 32'd0;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_sel   <= '0;
                        r_rdy   <= 1'b1;
                        r_rdata <= r_rnw ? ERR_DATA : 32'd0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (epc_cs_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign epc_rdy   = r_rdy;
    assign epc_rdata = r_rdata;
    assign reg_sel   = r_sel;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign reg_addr  = r_reg_addr;
    assign reg_be    = r_be;
    assign reg_wdata = r_wdata;
    assign err_flag  = r_err_flag;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/epc_reg_ctl.md
# epc_reg_ctl

EPC register-bus controller between the PS EPC interface (OCXO_CLK100 domain) and the PL register slaves. It decodes each single-beat EPC access to one of NSLV slave selects and sequences a one-request/one-ack handshake to that slave. It returns read data with a one-cycle `epc_rdy` pulse, and terminates unmapped or unresponsive accesses with an error response so the CPU never hangs.

## Interface
Parameters:
- SEL_LSB, 8, lowest address bit of the slave index field
- SEL_W, 5, width of the slave index field; NSLV = 2**SEL_W
- ADDR_W, 16, address bits decoded; any set bit in addr[31:ADDR_W] or addr[ADDR_W-1:SEL_LSB+SEL_W] is unmapped
- TMO, 16, cycles to wait for a slave ack before timeout (1..65535)
- ERR_DATA, 32'hdead_beef, read data returned on an error

Ports:
- clk, in, 1, OCXO 100 MHz clock; the only clock
- rst_n, in, 1, asynchronous active-low reset
- epc_cs_n, in, 1, chip select from EPC, active low
- epc_ads, in, 1, address strobe; one-cycle pulse marks the start of an access
- epc_rnw, in, 1, 1 = read, 0 = write
- epc_addr, in, 32, byte address, sampled on ads
- epc_be, in, 4, byte enables, sampled on ads
- epc_wdata, in, 32, write data, sampled on ads
- epc_rdata, out, 32, read data, valid while epc_rdy = 1
- epc_rdy, out, 1, one-cycle completion pulse
- reg_sel, out, NSLV, one-hot slave select; held from request to ack
- reg_addr, out, SEL_LSB-2, word offset within the slave (addr[SEL_LSB-1:2])
- reg_be, out, 4, latched byte enables
- reg_wdata, out, 32, latched write data
- reg_wr, out, 1, one-cycle write strobe
- reg_rd, out, 1, one-cycle read strobe
- reg_rdata, in, 32*NSLV, flattened slave read data; slave i drives bits [32*i+31:32*i]
- reg_ack, in, NSLV, per-slave one-cycle ack
- err_flag, out, 1, sticky error (unmapped or timeout); cleared by a write of any value to the controller's own word 0x0000_0000 (slave 0, offset 0 is reserved for this)
- err_cnt, out, 16, saturating error count

## Operation
- States: IDLE, DECODE, ACCESS, RESP, HOLD.
- IDLE: when epc_cs_n = 0 and epc_ads = 1, latch addr, be, wdata, rnw, then go to DECODE. An ads while not in IDLE is ignored.
- DECODE:
  - Unmapped address: go to RESP with error.
  - Address 0 with a write: clear err_flag and err_cnt internally, then go to RESP with no error.
  - Otherwise: assert reg_sel, pulse reg_wr or reg_rd for one cycle, then go to ACCESS.
- ACCESS: count from 0.
  - reg_ack of the selected slave: capture that slave's rdata, go to RESP.
  - Count reaches TMO-1 with no ack: go to RESP with error.
  - Ack and timeout in the same cycle: the ack wins, no error.
  - Acks from non-selected slaves are ignored.
- RESP: epc_rdy = 1 for one cycle.
  - epc_rdata = captured data on a successful read, ERR_DATA on a read error, 0 on a write.
  - On error: set err_flag and increment err_cnt, saturating at 16'hffff.
  - reg_sel drops. Go to HOLD.
- HOLD: wait for epc_cs_n = 1, then go to IDLE. A new access needs cs_n to return high first.
- epc_cs_n rising before RESP aborts the access: drop reg_sel, give no rdy, go to IDLE, no error.

## Timing
- Reset values: epc_rdy = 0, epc_rdata = 0, reg_sel = 0, reg_wr = 0, reg_rd = 0, reg_addr = 0, reg_be = 0, reg_wdata = 0, err_flag = 0, err_cnt = 0; state = IDLE.
- All outputs are registered.
- Latency, ads cycle counted as cycle 0:
  - reg_rd or reg_wr strobe at cycle 2.
  - Slave ack at cycle 2+k gives epc_rdy at cycle 3+k.
  - Unmapped access gives epc_rdy at cycle 2.
  - Timeout gives epc_rdy at cycle 2+TMO.
- rst_n asserted mid-access forces the reset values immediately (asynchronous). No rdy is issued afterwards.

## Structure
- Shared package `epc_pkg`: state enum `epc_state_t`, ERR_DATA default, and the reserved control address constant.
- One sub-module `epc_decode`: combinational address-to-one-hot decode plus the unmapped flag, reused by future bus bridges.

## Test plan
- Write 0x12345678 to 0x100, slave 1 acks after 3 cycles -> reg_sel[1] asserted, reg_wdata = 0x12345678, one reg_wr pulse, epc_rdy 1 cycle after the ack, err_flag = 0.
- Read 0x314, slave 3 drives 0x0000_004f and acks after 1 cycle -> epc_rdata = 0x0000_004f with rdy, reg_addr = 0x05.
- Read 0xa5a5a5a5 (unmapped) -> no reg_sel, rdy at cycle 2, rdata = 0xdeadbeef, err_flag = 1, err_cnt = 1.
- Read 0x200, no ack, TMO = 16 -> rdy at cycle 18, rdata = 0xdeadbeef, err_cnt increments. Repeat the case with the ack arriving on the timeout cycle -> real data, no error.
- cs_n deasserted during ACCESS, then rst_n pulsed mid-access -> no rdy, all outputs at reset values, next access completes normally.
- Write to 0x0 after errors -> err_flag = 0, err_cnt = 0, rdy issued. Force 65536 errors -> err_cnt holds at 0xffff.
